// File: rtl/rx_word_fifo_if.sv
// Receiver-to-FIFO capture handshake and FIFO drain port.
// The master side drives the capture inputs and the drain ready; the FIFO is the slave side.
interface rx_word_fifo_if #(
    parameter int unsigned WIDTH = 8
);
    logic             ack;
    logic [WIDTH-1:0] data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output ack,
        output data,
        output out_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  ack,
        input  data,
        input  out_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/rx_word_fifo.sv
// Captures one receiver word per ack rising edge into a FIFO drained by valid/ready,
// and tracks the sender's incrementing sequence for overflow/sequence-error debug.
module rx_word_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk1,
    input  logic                     rst,
    rx_word_fifo_if.slave            bus,
    input  logic                     clear,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic                     seq_err,
    output logic [7:0]               err_count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic             ack_q;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             overflow_q;
    logic             seq_err_q;
    logic [7:0]       err_cnt;
    logic [WIDTH-1:0] exp_word;
    logic             seq_init;

    logic push_evt;
    logic push;
    logic pop;
    logic drop;
    logic full_w;
    logic empty_w;

    // Occupancy flags decode straight from the count register.
    assign full_w  = (cnt == CW'(DEPTH));
    assign empty_w = (cnt == CW'(0));

    // One event per receiver transfer regardless of how long ack stays high.
    assign push_evt = bus.ack & ~ack_q;
    assign pop      = ~empty_w & bus.out_ready;
    assign push     = push_evt & (~full_w | pop);
    assign drop     = push_evt & full_w & ~pop;

    assign count         = cnt;
    assign full          = full_w;
    assign empty         = empty_w;
    assign bus.out_valid = ~empty_w;
    assign bus.out_data  = mem[rd_ptr];
    assign overflow      = overflow_q;
    assign seq_err       = seq_err_q;
    assign err_count     = err_cnt;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= bus.ack;
        end
    end

    // Storage is deliberately not reset; out_data is only meaningful while out_valid.
    always_ff @(posedge clk1) begin
        if (push) begin
            mem[wr_ptr] <= bus.data;
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Sequence tracker also sees dropped words so it stays aligned with the sender.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
            seq_err_q  <= 1'b0;
            err_cnt    <= 8'd0;
            exp_word   <= '0;
            seq_init   <= 1'b0;
        end else if (clear) begin
            overflow_q <= 1'b0;
            seq_err_q  <= 1'b0;
            err_cnt    <= 8'd0;
            seq_init   <= push_evt;
            if (push_evt) begin
                exp_word <= bus.data + WIDTH'(1);
            end
        end else begin
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (push_evt) begin
                exp_word <= bus.data + WIDTH'(1);
                seq_init <= 1'b1;
                if (seq_init && (bus.data != exp_word)) begin
                    seq_err_q <= 1'b1;
                    if (err_cnt != 8'hFF) begin
                        err_cnt <= err_cnt + 8'd1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_rx_word_fifo.sv
// Directed bench for rx_word_fifo: capture, drain order, overflow, sequence check, clear, reset.
module tb_rx_word_fifo;
    logic       clk1;
    logic       rst;
    logic       clear;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       seq_err;
    logic [7:0] err_count;

    int n_vec;
    int n_err;

    rx_word_fifo_if #(.WIDTH(8)) bus ();

    rx_word_fifo #(.WIDTH(8), .DEPTH(8)) dut (
        .clk1      (clk1),
        .rst       (rst),
        .bus       (bus.slave),
        .clear     (clear),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .seq_err   (seq_err),
        .err_count (err_count)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    // One receiver transfer: ack high for one cycle, then low for one cycle.
    task automatic send(input logic [7:0] w);
        bus.ack  = 1'b1;
        bus.data = w;
        step();
        bus.ack = 1'b0;
        step();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        clear         = 1'b0;
        bus.ack       = 1'b0;
        bus.data      = 8'h00;
        bus.out_ready = 1'b0;
        step();
        step();
        n_vec++;
        if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_occ got count=%0d empty=%b full=%b valid=%b want 0 1 0 0",
                     count, empty, full, bus.out_valid);
        end
        n_vec++;
        if (overflow !== 1'b0 || seq_err !== 1'b0 || err_count !== 8'd0) begin
            n_err++;
            $display("FAIL reset_flags got ovf=%b seq=%b errs=%0d want 0 0 0", overflow, seq_err, err_count);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        send(8'd0);
        send(8'd1);
        send(8'd2);
        n_vec++;
        if (count !== 4'd3 || bus.out_data !== 8'd0 || seq_err !== 1'b0) begin
            n_err++;
            $display("FAIL basic_fill got count=%0d head=%0d seq=%b want 3 0 0", count, bus.out_data, seq_err);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(i)) begin
                n_err++;
                $display("FAIL basic_pop%0d got valid=%b data=%0d want 1 %0d", i, bus.out_valid, bus.out_data, i);
            end
            step();
        end
        bus.out_ready = 1'b0;
        n_vec++;
        if (empty !== 1'b1 || count !== 4'd0 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_empty got empty=%b count=%0d valid=%b want 1 0 0", empty, count, bus.out_valid);
        end
    endtask

    task automatic test_long_ack();
        pulse_clear();
        bus.ack  = 1'b1;
        bus.data = 8'h10;
        for (int i = 0; i < 5; i++) step();
        bus.ack = 1'b0;
        step();
        n_vec++;
        if (count !== 4'd1 || bus.out_data !== 8'h10 || seq_err !== 1'b0) begin
            n_err++;
            $display("FAIL long_ack got count=%0d head=%h seq=%b want 1 10 0", count, bus.out_data, seq_err);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        n_vec++;
        if (empty !== 1'b1) begin
            n_err++;
            $display("FAIL long_ack_drain got empty=%b want 1", empty);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] order [8];
        order = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd9};
        pulse_clear();
        for (int i = 0; i < 8; i++) send(8'(i));
        n_vec++;
        if (full !== 1'b1 || count !== 4'd8 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_fill got full=%b count=%0d ovf=%b want 1 8 0", full, count, overflow);
        end
        send(8'd8);
        n_vec++;
        if (overflow !== 1'b1 || count !== 4'd8 || seq_err !== 1'b0 || bus.out_data !== 8'd0) begin
            n_err++;
            $display("FAIL ovf_drop got ovf=%b count=%0d seq=%b head=%0d want 1 8 0 0",
                     overflow, count, seq_err, bus.out_data);
        end
        // Push and pop on the same edge while full.
        bus.ack       = 1'b1;
        bus.data      = 8'd9;
        bus.out_ready = 1'b1;
        step();
        bus.ack       = 1'b0;
        bus.out_ready = 1'b0;
        step();
        n_vec++;
        if (count !== 4'd8 || full !== 1'b1 || overflow !== 1'b1 || bus.out_data !== 8'd1 || seq_err !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_pushpop got count=%0d full=%b ovf=%b head=%0d seq=%b want 8 1 1 1 0",
                     count, full, overflow, bus.out_data, seq_err);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== order[i]) begin
                n_err++;
                $display("FAIL ovf_order%0d got valid=%b data=%0d want 1 %0d", i, bus.out_valid, bus.out_data, order[i]);
            end
            step();
        end
        bus.out_ready = 1'b0;
        n_vec++;
        if (empty !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_drain got empty=%b want 1", empty);
        end
    endtask

    task automatic test_seq_wrap();
        pulse_clear();
        send(8'd254);
        send(8'd255);
        send(8'd0);
        send(8'd1);
        n_vec++;
        if (seq_err !== 1'b0 || err_count !== 8'd0 || count !== 4'd4) begin
            n_err++;
            $display("FAIL seq_wrap got seq=%b errs=%0d count=%0d want 0 0 4", seq_err, err_count, count);
        end
        send(8'd5);
        n_vec++;
        if (seq_err !== 1'b1 || err_count !== 8'd1) begin
            n_err++;
            $display("FAIL seq_gap got seq=%b errs=%0d want 1 1", seq_err, err_count);
        end
        send(8'd6);
        n_vec++;
        if (err_count !== 8'd1 || count !== 4'd6) begin
            n_err++;
            $display("FAIL seq_resync got errs=%0d count=%0d want 1 6", err_count, count);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_clear_same_cycle();
        pulse_clear();
        send(8'h20);
        send(8'h30);
        n_vec++;
        if (seq_err !== 1'b1 || err_count !== 8'd1 || count !== 4'd2) begin
            n_err++;
            $display("FAIL clr_setup got seq=%b errs=%0d count=%0d want 1 1 2", seq_err, err_count, count);
        end
        bus.ack  = 1'b1;
        bus.data = 8'h40;
        clear    = 1'b1;
        step();
        clear   = 1'b0;
        bus.ack = 1'b0;
        step();
        n_vec++;
        if (seq_err !== 1'b0 || err_count !== 8'd0 || overflow !== 1'b0 || count !== 4'd3) begin
            n_err++;
            $display("FAIL clr_push got seq=%b errs=%0d ovf=%b count=%0d want 0 0 0 3",
                     seq_err, err_count, overflow, count);
        end
        send(8'h41);
        n_vec++;
        if (seq_err !== 1'b0 || err_count !== 8'd0 || count !== 4'd4 || bus.out_data !== 8'h20) begin
            n_err++;
            $display("FAIL clr_next got seq=%b errs=%0d count=%0d head=%h want 0 0 4 20",
                     seq_err, err_count, count, bus.out_data);
        end
        // Asynchronous reset mid-cycle, checked before the next clock edge.
        @(negedge clk1);
        rst = 1'b1;
        #1;
        n_vec++;
        if (count !== 4'd0 || empty !== 1'b1 || bus.out_valid !== 1'b0 || full !== 1'b0) begin
            n_err++;
            $display("FAIL async_rst got count=%0d empty=%b valid=%b full=%b want 0 1 0 0",
                     count, empty, bus.out_valid, full);
        end
        n_vec++;
        if (overflow !== 1'b0 || seq_err !== 1'b0 || err_count !== 8'd0) begin
            n_err++;
            $display("FAIL async_rst_flags got ovf=%b seq=%b errs=%0d want 0 0 0", overflow, seq_err, err_count);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_long_ack();
        test_overflow();
        test_seq_wrap();
        test_clear_same_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
